// File: rtl/sm1118_node_navigator.sv
// Line-following node navigator: debounces node markers, counts nodes along a route,
// executes timed turns, and reports status identifiers through a request/ack handshake.
module sm1118_node_navigator #(
    parameter int unsigned DEB_CYCLES  = 3125,
    parameter int unsigned TURN_CYCLES = 1562500,
    parameter int unsigned LAST_NODE   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       node_det,
    input  logic [5:0] nodex,
    input  logic [2:0] turn,
    input  logic [1:0] statusno,
    input  logic       msg_ack,
    output logic [5:0] node,
    output logic [2:0] motor_cmd,
    output logic       msg_req,
    output logic [1:0] msg_si,
    output logic       done
);

    localparam int unsigned DW = (DEB_CYCLES  < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);

    localparam logic [5:0]    LAST_N   = 6'(LAST_NODE);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TRN_LAST = TW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_SETTLE,
        S_TURN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            det_q, det_d;
    logic            det_prev_q;
    logic [5:0]      node_q, node_d;
    logic            settle_q, settle_d;
    logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
    logic [2:0]      turn_s_q, turn_s_d;
    logic [1:0]      status_s_q, status_s_d;
    logic [1:0]      si_q, si_d;
    logic            arrival;

    // Debouncer: count consecutive samples that disagree with det_q; any agreeing sample restarts.
    always_comb begin
        det_d     = det_q;
        deb_cnt_d = '0;
        if (node_det != det_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                det_d = node_det;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign arrival = det_q & ~det_prev_q;

    always_comb begin
        state_d    = state_q;
        node_d     = node_q;
        settle_d   = 1'b0;
        turn_cnt_d = '0;
        turn_s_d   = turn_s_q;
        status_s_d = status_s_q;
        si_d       = si_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FOLLOW;
            end
            S_FOLLOW: begin
                if (arrival) begin
                    node_d  = node_q + 6'd1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Planner outputs are valid only on the second settle cycle.
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else begin
                    turn_s_d   = turn;
                    status_s_d = statusno;
                    if (node_q == LAST_N && statusno == 2'd0) begin
                        state_d = S_DONE;
                    end else if (node_q == nodex && (turn == 3'd5 || turn == 3'd6)) begin
                        state_d = S_TURN;
                    end else if (statusno != 2'd0) begin
                        state_d = S_REPORT;
                        si_d    = statusno;
                    end else begin
                        state_d = S_FOLLOW;
                    end
                end
            end
            S_TURN: begin
                if (turn_cnt_q == TRN_LAST) begin
                    if (status_s_q != 2'd0) begin
                        state_d = S_REPORT;
                        si_d    = status_s_q;
                    end else if (node_q == LAST_N) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FOLLOW;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (msg_ack) state_d = (node_q == LAST_N) ? S_DONE : S_FOLLOW;
            end
            S_DONE: begin
                if (start) begin
                    node_d  = '0;
                    state_d = S_FOLLOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            deb_cnt_q  <= '0;
            det_q      <= 1'b0;
            det_prev_q <= 1'b0;
            node_q     <= '0;
            settle_q   <= 1'b0;
            turn_cnt_q <= '0;
            turn_s_q   <= '0;
            status_s_q <= '0;
            si_q       <= '0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            det_q      <= det_d;
            det_prev_q <= det_q;
            node_q     <= node_d;
            settle_q   <= settle_d;
            turn_cnt_q <= turn_cnt_d;
            turn_s_q   <= turn_s_d;
            status_s_q <= status_s_d;
            si_q       <= si_d;
        end
    end

    always_comb begin
        motor_cmd = 3'd0;
        case (state_q)
            S_FOLLOW, S_SETTLE: motor_cmd = 3'd1;
            S_TURN:             motor_cmd = turn_s_q;
            default:            motor_cmd = 3'd0;
        endcase
    end

    assign node    = node_q;
    assign msg_req = (state_q == S_REPORT);
    assign msg_si  = si_q;
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sm1118_node_navigator.sv
// Scoreboard bench: stimulus queues the expected sequence of output changes (with cycle
// spacing where it matters); a monitor pops and checks one entry per observed change.
module tb_sm1118_node_navigator;

    localparam int unsigned DEB   = 8;
    localparam int unsigned TURNC = 40;
    localparam int unsigned LAST  = 7;
    localparam int unsigned GAP   = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       node_det = 1'b0;
    logic [5:0] nodex = '0;
    logic [2:0] turn = '0;
    logic [1:0] statusno = '0;
    logic       msg_ack = 1'b0;
    logic [5:0] node;
    logic [2:0] motor_cmd;
    logic       msg_req;
    logic [1:0] msg_si;
    logic       done;

    sm1118_node_navigator #(
        .DEB_CYCLES (DEB),
        .TURN_CYCLES(TURNC),
        .LAST_NODE  (LAST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .node_det (node_det),
        .nodex    (nodex),
        .turn     (turn),
        .statusno (statusno),
        .msg_ack  (msg_ack),
        .node     (node),
        .motor_cmd(motor_cmd),
        .msg_req  (msg_req),
        .msg_si   (msg_si),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [12:0] v;
        int          dur;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void push(input string name, input int n, input int mc, input int req,
                                 input int si, input int dn, input int dur);
        exp_t e;
        e.name = name;
        e.v    = {6'(n), 3'(mc), 1'(req), 2'(si), 1'(dn)};
        e.dur  = dur;
        q.push_back(e);
    endfunction

    // Monitor: every change of the output tuple consumes one expected entry.
    logic [12:0] prev_t = '0;
    int last_cyc = 0;
    always @(negedge clk) begin
        logic [12:0] cur;
        int dur;
        exp_t e;
        cur = {node, motor_cmd, msg_req, msg_si, done};
        if (cur !== prev_t) begin
            dur      = cyc - last_cyc;
            last_cyc = cyc;
            prev_t   = cur;
            compared = compared + 1;
            if (q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_change: got node=%0d motor=%0d req=%0b si=%0d done=%0b, required no change",
                         cur[12:7], cur[6:4], cur[3], cur[2:1], cur[0]);
            end else begin
                e = q.pop_front();
                if (cur !== e.v || (e.dur >= 0 && dur != e.dur)) begin
                    mismatched = mismatched + 1;
                    $display("FAIL %s: got node=%0d motor=%0d req=%0b si=%0d done=%0b after %0d cyc, required node=%0d motor=%0d req=%0b si=%0d done=%0b after %0d cyc",
                             e.name, cur[12:7], cur[6:4], cur[3], cur[2:1], cur[0], dur,
                             e.v[12:7], e.v[6:4], e.v[3], e.v[2:1], e.v[0], e.dur);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic arrive();
        node_det = 1'b1;
        tick(DEB + 4);
        node_det = 1'b0;
        tick(DEB + 4);
        tick(GAP);
    endtask

    task automatic ack_after(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (msg_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL wait_msg_req: got timeout after 200 cyc, required msg_req=1");
        end else begin
            if (n > 1) tick(n - 1);
            msg_ack = 1'b1;
            tick(1);
            msg_ack = 1'b0;
        end
    endtask

    task automatic wait_motor(input logic [2:0] mc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (motor_cmd === mc) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL wait_motor: got timeout, required motor_cmd=%0d", mc);
        end
    endtask

    initial begin
        tick(3);
        compared = compared + 1;
        if ({node, motor_cmd, msg_req, msg_si, done} !== 13'd0) begin
            mismatched = mismatched + 1;
            $display("FAIL reset_state: got node=%0d motor=%0d req=%0b si=%0d done=%0b, required all 0",
                     node, motor_cmd, msg_req, msg_si, done);
        end
        rst_n = 1'b1;
        tick(2);

        push("start_follow", 0, 1, 0, 0, 0, -1);
        pulse_start();
        tick(3);
        pulse_start();
        msg_ack = 1'b1;
        tick(1);
        msg_ack = 1'b0;
        tick(3);

        push("bounce_arrival", 1, 1, 0, 0, 0, -1);
        for (int i = 0; i < 25; i++) begin
            node_det = ~node_det;
            tick(2);
        end
        arrive();

        nodex = 6'd2; turn = 3'd5; statusno = 2'd0;
        push("arr2", 2, 1, 0, 0, 0, -1);
        push("turn_right", 2, 5, 0, 0, 0, 2);
        push("turn_end", 2, 1, 0, 0, 0, TURNC);
        arrive();

        nodex = 6'd0;
        push("arr3_no_match", 3, 1, 0, 0, 0, -1);
        arrive();

        turn = 3'd0;
        push("arr4", 4, 1, 0, 0, 0, -1);
        arrive();

        nodex = 6'd6; statusno = 2'd1;
        push("arr5", 5, 1, 0, 0, 0, -1);
        push("report5", 5, 0, 1, 1, 0, 2);
        push("report5_end", 5, 1, 0, 1, 0, 10);
        fork
            arrive();
            ack_after(10);
        join

        nodex = 6'd0; statusno = 2'd0;
        push("arr6", 6, 1, 0, 1, 0, -1);
        arrive();

        statusno = 2'd2;
        push("arr7", 7, 1, 0, 1, 0, -1);
        push("report7", 7, 0, 1, 2, 0, 2);
        push("final_done", 7, 0, 0, 2, 1, 3);
        fork
            arrive();
            ack_after(3);
        join

        push("restart", 0, 1, 0, 2, 0, -1);
        pulse_start();
        tick(3);

        nodex = 6'd1; turn = 3'd6; statusno = 2'd0;
        push("arr1_b", 1, 1, 0, 2, 0, -1);
        push("turn_left", 1, 6, 0, 2, 0, 2);
        push("reset_mid_turn", 0, 0, 0, 0, 0, -1);
        fork
            arrive();
            begin
                wait_motor(3'd6);
                tick(10);
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        join
        arrive();
        arrive();

        push("start_after_reset", 0, 1, 0, 0, 0, -1);
        pulse_start();
        tick(3);

        nodex = 6'd1; turn = 3'd5; statusno = 2'd3;
        push("arr1_c", 1, 1, 0, 0, 0, -1);
        push("turn_then_report", 1, 5, 0, 0, 0, 2);
        push("report_after_turn", 1, 0, 1, 3, 0, TURNC);
        push("report_ack_1", 1, 1, 0, 3, 0, 1);
        fork
            arrive();
            ack_after(1);
        join
        tick(5);

        compared = compared + 1;
        if (q.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL pending_expectations: got %0d left, required 0 (next %s)", q.size(), q[0].name);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sm1118_node_navigator.md
SM1118_NODE_NAVIGATOR -- requirements
Module: sm1118_node_navigator

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 3125, consecutive cycles node_det must be stable to be accepted (1 ms at 3.125 MHz).
REQ-002 SHALL have parameter TURN_CYCLES, default 1562500, cycles motor_cmd holds a turn code (0.5 s).
REQ-003 SHALL have parameter LAST_NODE, default 7, final node index of the route.
REQ-004 clk  input  1  3.125 MHz system clock; the only clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle pulse; begins route traversal from IDLE.
REQ-007 node_det  input  1  raw line-sensor node-marker level, high while the bot is on a node, may bounce.
REQ-008 nodex  input  6  next turn node from the path planner.
REQ-009 turn  input  3  turn code from the path planner: 5 right, 6 left, others no turn.
REQ-010 statusno  input  2  status-identifier number for the current node from the path planner; 0 means none.
REQ-011 msg_ack  input  1  message transmitter has accepted msg_si.
REQ-012 node  output  6  current node index, fed back to the path planner.
REQ-013 motor_cmd  output  3  0 stop, 1 forward, 5 right turn, 6 left turn.
REQ-014 msg_req  output  1  request to transmit msg_si.
REQ-015 msg_si  output  2  SI number captured at the current node.
REQ-016 done  output  1  high while in DONE.

Function
REQ-017 SHALL implement states IDLE, FOLLOW, SETTLE, TURN, REPORT, DONE.
REQ-018 Debouncer SHALL set det_q=1 after node_det is high for DEB_CYCLES consecutive cycles and set det_q=0 after it is low for DEB_CYCLES consecutive cycles; any opposite sample restarts the count.
REQ-019 Arrival event SHALL be the rising edge of det_q, one cycle wide; arrivals SHALL be ignored outside FOLLOW.
REQ-020 IDLE: motor_cmd=0; on start go to FOLLOW with node unchanged at 0.
REQ-021 FOLLOW: motor_cmd=1; on arrival, node increments by 1 in the same edge and state goes to SETTLE.
REQ-022 SETTLE SHALL last exactly 2 cycles with motor_cmd=1, covering the planner's one-cycle registered latency; nodex, turn, statusno SHALL be sampled on the last SETTLE cycle.
REQ-023 After SETTLE: if node==LAST_NODE and statusno==0 go to DONE; else if node==nodex and turn is 5 or 6 go to TURN; else if statusno!=0 go to REPORT; else go to FOLLOW.
REQ-024 TURN: motor_cmd equals the sampled turn for exactly TURN_CYCLES cycles, then proceed as REQ-023 minus the turn check (REPORT if sampled statusno!=0, DONE if node==LAST_NODE, else FOLLOW).
REQ-025 REPORT: motor_cmd=0, msg_si=sampled statusno, msg_req=1 held until the cycle msg_ack is sampled high; the next cycle msg_req=0 and state goes to DONE if node==LAST_NODE else FOLLOW.
REQ-026 msg_ack outside REPORT SHALL be ignored; msg_si SHALL hold its value until the next REPORT entry.
REQ-027 DONE: motor_cmd=0, done=1, node held; start SHALL clear node to 0 and go to FOLLOW.
REQ-028 Turn timer SHALL be sized to ceil(log2(TURN_CYCLES+1)) bits and never wrap; debounce counter likewise for DEB_CYCLES.
REQ-029 start in any state other than IDLE or DONE SHALL be ignored.
REQ-030 node SHALL never exceed LAST_NODE; an arrival when node==LAST_NODE is unreachable because FOLLOW is not entered then.

Reset
REQ-031 While rst_n=0: state IDLE, node=0, motor_cmd=0, msg_req=0, msg_si=0, done=0, det_q=0, all counters 0.
REQ-032 Reset asserted mid-TURN or mid-REPORT SHALL abort immediately to the values of REQ-031 with no pending request retained.

Verification
REQ-033 Bounce: start, node_det toggling every 100 cycles for 5000 cycles then high 3125 -> node stays 0 during bounce, becomes 1 exactly once.
REQ-034 Turn: arrival to node 2 with nodex=2, turn=5, statusno=0 -> after 2 SETTLE cycles motor_cmd=5 for 1562500 cycles, then motor_cmd=1.
REQ-035 Report: arrival to node 5, nodex=6, statusno=1, msg_ack after 10 cycles -> motor_cmd=0, msg_req=1, msg_si=1 for 10 cycles, then motor_cmd=1, msg_req=0.
REQ-036 Final: arrival to node 7 with statusno=2 -> REPORT, then done=1, motor_cmd=0, node=7; start -> node=0, motor_cmd=1.
REQ-037 Reset mid-TURN: rst_n low for 1 cycle at turn cycle 1000 -> all outputs 0, state IDLE; node_det arrivals ignored until start.
